// File: rtl/keypad_calc_ctrl.sv
// Keypad-driven calculator controller: hold/debounce, operand entry, op select, ALU launch.
// Optional build macro KCC_AUTOCLEAR_EN clears operands and overflow when a calculation completes.
module keypad_calc_ctrl #(
  parameter int DIGITS      = 4,
  parameter int HOLD_CYCLES = 10000,
  localparam int OPW        = 4 * DIGITS,
  localparam int IW         = $clog2(DIGITS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4:0]     key,
  input  logic           alu_done,
  output logic [1:0]     state,
  output logic [IW-1:0]  index,
  output logic           sel_b,
  output logic [2:0]     op_code,
  output logic [OPW-1:0] opa,
  output logic [OPW-1:0] opb,
  output logic           alu_start,
  output logic           overflow
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_FULL  = IW'(DIGITS);

  typedef enum logic [1:0] {
    S_WPR  = 2'd0,
    S_GON  = 2'd1,
    S_OP   = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [IW-1:0]  index_r, index_s;
  logic           sel_b_r, sel_b_s;
  logic [2:0]     op_code_r, op_code_s;
  logic [OPW-1:0] opa_r, opa_s, opb_r, opb_s;
  logic           alu_start_r, alu_start_s;
  logic           overflow_r, overflow_s;
  logic           done_seen_r, done_seen_s;
  logic           expired_s;

  // Newest digit enters the low nibble, oldest digit falls off the top.
  function automatic logic [OPW-1:0] shift_digit(input logic [OPW-1:0] val, input logic [3:0] code);
    shift_digit = (val << 4) | OPW'(code);
  endfunction

  function automatic logic [2:0] op_decode(input logic [3:0] code);
    case (code)
      4'hB:    op_decode = 3'd1;
      4'hC:    op_decode = 3'd2;
      4'hD:    op_decode = 3'd3;
      4'hE:    op_decode = 3'd4;
      4'hF:    op_decode = 3'd5;
      default: op_decode = 3'd0;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_WPR;
      cnt_r       <= '0;
      index_r     <= '0;
      sel_b_r     <= 1'b0;
      op_code_r   <= 3'd0;
      opa_r       <= '0;
      opb_r       <= '0;
      alu_start_r <= 1'b0;
      overflow_r  <= 1'b0;
      done_seen_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      index_r     <= index_s;
      sel_b_r     <= sel_b_s;
      op_code_r   <= op_code_s;
      opa_r       <= opa_s;
      opb_r       <= opb_s;
      alu_start_r <= alu_start_s;
      overflow_r  <= overflow_s;
      done_seen_r <= done_seen_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    index_s     = index_r;
    sel_b_s     = sel_b_r;
    op_code_s   = op_code_r;
    opa_s       = opa_r;
    opb_s       = opb_r;
    alu_start_s = 1'b0;
    overflow_s  = overflow_r;
    done_seen_s = done_seen_r;
    expired_s   = (cnt_r == HOLD_LAST);

    case (state_r)
      S_WPR: begin
        if (key[4]) begin
          cnt_s = '0;
          if (key[3:0] <= 4'd9) begin
            if (index_r < IDX_FULL) begin
              if (sel_b_r) begin
                opb_s = shift_digit(opb_r, key[3:0]);
              end else begin
                opa_s = shift_digit(opa_r, key[3:0]);
              end
              index_s = index_r + IW'(1);
            end else begin
              overflow_s = 1'b1;
            end
            state_s = S_GON;
          end else if (key[3:0] == 4'hA) begin
            sel_b_s = ~sel_b_r;
            index_s = '0;
            state_s = S_GON;
          end else begin
            op_code_s = op_decode(key[3:0]);
            index_s   = '0;
            state_s   = S_OP;
          end
        end else begin
          state_s = S_WPR;
        end
      end
      S_GON: begin
        if (expired_s) begin
          cnt_s = '0;
          if (!key[4]) begin
            state_s = S_WPR;
          end else begin
            state_s = S_GON;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_OP: begin
        if (expired_s) begin
          cnt_s = '0;
          if (!key[4]) begin
            state_s     = S_EXEC;
            alu_start_s = 1'b1;
            done_seen_s = 1'b0;
          end else begin
            state_s = S_OP;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_EXEC: begin
        // A done that arrives while the key is still held is remembered until release.
        if ((done_seen_r || alu_done) && !key[4]) begin
          state_s     = S_WPR;
          sel_b_s     = 1'b0;
          index_s     = '0;
          done_seen_s = 1'b0;
`ifdef KCC_AUTOCLEAR_EN
          opa_s      = '0;
          opb_s      = '0;
          overflow_s = 1'b0;
`endif
        end else if (alu_done) begin
          done_seen_s = 1'b1;
        end else begin
          done_seen_s = done_seen_r;
        end
      end
      default: begin
        state_s = S_WPR;
      end
    endcase
  end

  assign state     = state_r;
  assign index     = index_r;
  assign sel_b     = sel_b_r;
  assign op_code   = op_code_r;
  assign opa       = opa_r;
  assign opb       = opb_r;
  assign alu_start = alu_start_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_keypad_calc_ctrl.sv
// Self-checking bench for keypad_calc_ctrl (DIGITS=4, HOLD_CYCLES=4): directed scenarios
// plus randomized key/done traffic, compared every cycle against a behavioural model.
module tb_keypad_calc_ctrl;

  localparam int DIGITS = 4;
  localparam int H      = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  key;
  logic        alu_done;
  logic [1:0]  state;
  logic [2:0]  index;
  logic        sel_b;
  logic [2:0]  op_code;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        alu_start;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // Model of the controller, phrased as elapsed time in a phase rather than a counter.
  int m_state;
  int m_el;
  bit m_done;
  int m_opa, m_opb;
  int m_idx;
  bit m_selb;
  int m_op;
  bit m_start;
  bit m_ovf;

  keypad_calc_ctrl #(.DIGITS(DIGITS), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .key(key), .alu_done(alu_done),
    .state(state), .index(index), .sel_b(sel_b), .op_code(op_code),
    .opa(opa), .opb(opb), .alu_start(alu_start), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [4:0] k, input logic d, input logic r);
    int c;
    c = int'(k[3:0]);
    m_start = 1'b0;
    if (r) begin
      m_state = 0; m_el = 0; m_done = 0; m_opa = 0; m_opb = 0;
      m_idx = 0; m_selb = 0; m_op = 0; m_ovf = 0;
    end else begin
      case (m_state)
        0: if (k[4]) begin
          m_el = 0;
          if (c < 10) begin
            if (m_idx < DIGITS) begin
              if (m_selb) m_opb = (m_opb * 16 + c) % 65536;
              else        m_opa = (m_opa * 16 + c) % 65536;
              m_idx++;
            end else begin
              m_ovf = 1;
            end
            m_state = 1;
          end else if (c == 10) begin
            m_selb = !m_selb; m_idx = 0; m_state = 1;
          end else begin
            m_op = c - 10; m_idx = 0; m_state = 2;
          end
        end
        1, 2: begin
          if ((m_el % H) == H - 1 && !k[4]) begin
            if (m_state == 1) begin
              m_state = 0;
            end else begin
              m_state = 3; m_start = 1; m_done = 0;
            end
          end
          m_el++;
        end
        default: begin
          if ((m_done || d) && !k[4]) begin
            m_state = 0; m_selb = 0; m_idx = 0;
`ifdef KCC_AUTOCLEAR_EN
            m_opa = 0; m_opb = 0; m_ovf = 0;
`endif
          end else if (d) begin
            m_done = 1;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input logic [4:0] k, input logic d, input logic r);
    key = k; alu_done = d; rst = r;
    @(posedge clk);
    model_step(k, d, r);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("index", 32'(index), 32'(m_idx));
    check("sel_b", 32'(sel_b), 32'(m_selb));
    check("op_code", 32'(op_code), 32'(m_op));
    check("opa", 32'(opa), 32'(m_opa));
    check("opb", 32'(opb), 32'(m_opb));
    check("alu_start", 32'(alu_start), 32'(m_start));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic press(input int code, input int hold, input int gap);
    repeat (hold) cyc({1'b1, 4'(code)}, 1'b0, 1'b0);
    repeat (gap) cyc(5'd0, 1'b0, 1'b0);
  endtask

  int code, hold, gap;

  initial begin
    key = 5'd0; alu_done = 1'b0; rst = 1'b1;
    cyc(5'd0, 1'b0, 1'b1);
    cyc(5'd0, 1'b0, 1'b1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_opa", 32'(opa), 32'd0);
    cyc(5'd0, 1'b0, 1'b0);

    // Reset while in S_OP
    press(12, 3, 0);
    check("t1_pre_state", 32'(state), 32'd2);
    cyc(5'b1_1100, 1'b0, 1'b1);
    check("t1_state", 32'(state), 32'd0);
    check("t1_op", 32'(op_code), 32'd0);
    check("t1_start", 32'(alu_start), 32'd0);

    // Long hold accepts a single digit
    press(7, 12, 0);
    check("t3_state_held", 32'(state), 32'd1);
    check("t3_opa", 32'(opa), 32'h7);
    check("t3_index", 32'(index), 32'd1);
    press(7, 0, 5);
    check("t3_state_rel", 32'(state), 32'd0);
    cyc(5'd0, 1'b0, 1'b1);

    // Four digits, then overflow
    press(1, 1, 5); press(2, 1, 5); press(3, 1, 5); press(4, 1, 5);
    check("t2_opa", 32'(opa), 32'h1234);
    check("t2_index", 32'(index), 32'd4);
    press(5, 1, 5);
    check("t2_opa_ovf", 32'(opa), 32'h1234);
    check("t2_ovf", 32'(overflow), 32'd1);

    // Operand B entry and SUB launch
    press(10, 1, 5); press(9, 1, 5); press(8, 1, 5);
    press(12, 1, 0);
    check("t4_opb", 32'(opb), 32'h0098);
    check("t4_selb", 32'(sel_b), 32'd1);
    check("t4_op", 32'(op_code), 32'd2);
    check("t4_state", 32'(state), 32'd2);
    press(12, 0, 4);
    check("t4_start", 32'(alu_start), 32'd1);
    check("t4_exec", 32'(state), 32'd3);

    // Done while key held, then release
    cyc(5'b1_0000, 1'b1, 1'b0);
    check("t5_hold", 32'(state), 32'd3);
    cyc(5'b1_0000, 1'b0, 1'b0);
    check("t5_nostart", 32'(alu_start), 32'd0);
    cyc(5'd0, 1'b0, 1'b0);
    check("t5_state", 32'(state), 32'd0);
    check("t5_selb", 32'(sel_b), 32'd0);
    check("t5_op_kept", 32'(op_code), 32'd2);
`ifdef KCC_AUTOCLEAR_EN
    check("t6_opa", 32'(opa), 32'd0);
    check("t6_opb", 32'(opb), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
`else
    check("t6_opa", 32'(opa), 32'h1234);
    check("t6_opb", 32'(opb), 32'h0098);
    check("t6_ovf", 32'(overflow), 32'd1);
`endif
    press(0, 0, 3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      code = ($urandom_range(0, 2) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 6));
      gap  = int'($urandom_range(0, 7));
      for (int i = 0; i < hold + gap; i++) begin
        cyc((i < hold) ? {1'b1, 4'(code)} : 5'd0,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
